// File: rtl/shift_universal.sv
// -----------------------------------------------------------------------------
// shift_universal
//
// WIDTH-bit universal shift register: hold, logical/arithmetic shift, rotate
// and parallel load, plus a burst engine that performs a programmed number of
// shifts (one per clock) with busy/done status.
//
// Parameters
//   WIDTH  register width in bits (>= 2)
//   CNT_W  width of the burst shift-count input
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-low reset
//   en      single-step enable while idle
//   mode    operation select (see mode_t)
//   sin_r   serial input entering the MSB on right shifts
//   sin_l   serial input entering the LSB on left shifts
//   din     parallel load data
//   start   burst start request (pulse)
//   amount  burst shift count
//   out     register contents (registered)
//   sout_r  out[0], bit leaving on right shifts
//   sout_l  out[WIDTH-1], bit leaving on left shifts
//   busy    high while a burst is in progress (registered)
//   done    one-cycle pulse at burst completion (registered)
//   parity  XOR reduction of out, registered (only with SHIFT_PARITY_EN)
//
// Build option
//   SHIFT_PARITY_EN  when defined, adds the parity output port and its logic.
// -----------------------------------------------------------------------------
module shift_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] out,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
`ifdef SHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SRL  = 3'b001,
    M_SLL  = 3'b010,
    M_ROR  = 3'b011,
    M_ROL  = 3'b100,
    M_SRA  = 3'b101,
    M_LOAD = 3'b110,
    M_RSVD = 3'b111
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  mode_t            burst_mode;
  logic [CNT_W-1:0] remaining;

  mode_t            live_mode;
  mode_t            step_mode;
  logic             start_burst;
  logic             start_zero;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_out;

  // One step of the selected operation applied to the current contents.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] cur,
    input mode_t            m,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (m)
      M_SRL:   res = {sr, cur[WIDTH-1:1]};
      M_SLL:   res = {cur[WIDTH-2:0], sl};
      M_ROR:   res = {cur[0], cur[WIDTH-1:1]};
      M_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_SRA:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_LOAD:  res = ld;
      default: res = cur;
    endcase
    return res;
  endfunction

  assign live_mode = mode_t'(mode);

  // Only the five shift/rotate modes can launch a burst; hold, load and the
  // reserved code leave start ignored so en decides instead.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    start_burst = 1'b0;
    start_zero  = 1'b0;
    if (state == IDLE && start &&
        (live_mode inside {M_SRL, M_SLL, M_ROR, M_ROL, M_SRA})) begin
      if (amount != '0) start_burst = 1'b1;
      else              start_zero  = 1'b1;
    end
  end

  always_comb begin
    step_mode = (state == BUSY) ? burst_mode : live_mode;
    shifted   = shift_step(out, step_mode, sin_r, sin_l, din);
    next_out  = out;
    if (state == BUSY)
      next_out = shifted;
    else if (!start_burst && !start_zero && en)
      next_out = shifted;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state      <= IDLE;
      burst_mode <= M_HOLD;
      remaining  <= '0;
      out        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SHIFT_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      out  <= next_out;
      done <= 1'b0;
`ifdef SHIFT_PARITY_EN
      parity <= ^next_out;
`endif
      case (state)
        IDLE: begin
          if (start_burst) begin
            burst_mode <= live_mode;
            remaining  <= amount;
            state      <= BUSY;
            busy       <= 1'b1;
          end else if (start_zero) begin
            done <= 1'b1;
          end
        end
        BUSY: begin
          remaining <= remaining - CNT_W'(1);
          // Last shift: done lines up with the final out value.
          if (remaining == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sout_r = out[0];
  assign sout_l = out[WIDTH-1];

endmodule

// File: tb/tb_shift_universal.sv
// -----------------------------------------------------------------------------
// tb_shift_universal
//
// Directed and randomised stimulus for shift_universal (WIDTH=8), compared
// every cycle against a transaction-level integer model of the register.
// -----------------------------------------------------------------------------
module tb_shift_universal;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] din;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] out;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;
`ifdef SHIFT_PARITY_EN
  logic             parity;
`endif

  int checks;
  int errors;

  // Model: contents, shifts still owed by the burst, burst operation, pulse.
  int m_out;
  int m_left;
  int m_bmode;
  bit m_done;

  shift_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .din    (din),
    .start  (start),
    .amount (amount),
    .out    (out),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
`ifdef SHIFT_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arithmetic description of one operation on an unsigned WIDTH-bit value.
  function automatic int apply(input int m, input int v, input int sr,
                               input int sl, input int d);
    case (m)
      1:       return (v >> 1) | (sr << (WIDTH - 1));
      2:       return ((v * 2) & MASK) | sl;
      3:       return (v >> 1) | ((v % 2) << (WIDTH - 1));
      4:       return ((v * 2) & MASK) | (v >> (WIDTH - 1));
      5:       return (v >> 1) | (v & (1 << (WIDTH - 1)));
      6:       return d & MASK;
      default: return v;
    endcase
  endfunction

  function automatic int parity_of(input int v);
    int p;
    p = 0;
    for (int i = 0; i < WIDTH; i++) p = p ^ ((v >> i) & 1);
    return p;
  endfunction

  // Drive one cycle of inputs, advance one edge, update the model, compare.
  task automatic cyc(input bit r, input bit e, input int m, input bit sr,
                     input bit sl, input int d, input bit st, input int am);
    reset  = r;
    en     = e;
    mode   = 3'(m);
    sin_r  = sr;
    sin_l  = sl;
    din    = WIDTH'(d);
    start  = st;
    amount = CNT_W'(am);
    @(posedge clk);
    if (!r) begin
      m_out  = 0;
      m_left = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_out  = apply(m_bmode, m_out, sr, sl, d);
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1;
      end else if (st && m >= 1 && m <= 5) begin
        if (am != 0) begin
          m_bmode = m;
          m_left  = am;
        end else begin
          m_done = 1;
        end
      end else if (e) begin
        m_out = apply(m, m_out, sr, sl, d);
      end
    end
    #1;
    check("out",    32'(out),    32'(m_out));
    check("busy",   32'(busy),   32'(m_left > 0));
    check("done",   32'(done),   32'(m_done));
    check("sout_r", 32'(sout_r), 32'(m_out & 1));
    check("sout_l", 32'(sout_l), 32'((m_out >> (WIDTH - 1)) & 1));
`ifdef SHIFT_PARITY_EN
    check("parity", 32'(parity), 32'(parity_of(m_out)));
`endif
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_out   = 0;
    m_left  = 0;
    m_bmode = 0;
    m_done  = 0;
    reset = 1'b0; en = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0;
    din = '0; start = 1'b0; amount = '0;

    // Reset overrides an enabled load of 0xFF.
    cyc(0, 1, 6, 0, 0, 8'hFF, 0, 0);
    cyc(0, 1, 6, 0, 0, 8'hFF, 0, 0);
    check("rst_out",  32'(out),  32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Load then SRL with sin_r=1.
    cyc(1, 1, 6, 0, 0, 8'hA5, 0, 0);
    check("load_a5", 32'(out), 32'hA5);
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    check("srl_d2",  32'(out),    32'hD2);
    check("srl_sor", 32'(sout_r), 32'h0);

    // SRA keeps the sign; SLL drops the MSB and takes sin_l.
    cyc(1, 1, 6, 0, 0, 8'h90, 0, 0);
    cyc(1, 1, 5, 0, 0, 0, 0, 0);
    check("sra_c8", 32'(out), 32'hC8);
    cyc(1, 1, 6, 0, 0, 8'h80, 0, 0);
    cyc(1, 1, 2, 0, 1, 0, 0, 0);
    check("sll_01", 32'(out), 32'h01);

    // ROR burst of 3, then back-to-back zero-amount start in the done cycle.
    cyc(1, 1, 6, 0, 0, 8'h81, 0, 0);
    cyc(1, 0, 3, 0, 0, 0, 1, 3);
    check("ror_b0_out",  32'(out),  32'h81);
    check("ror_b0_busy", 32'(busy), 32'h1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("ror_b1", 32'(out), 32'hC0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("ror_b2", 32'(out), 32'h60);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("ror_b3_out",  32'(out),  32'h30);
    check("ror_b3_done", 32'(done), 32'h1);
    check("ror_b3_busy", 32'(busy), 32'h0);
    cyc(1, 0, 3, 0, 0, 0, 1, 0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_out",  32'(out),  32'h30);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("zero_done_clr", 32'(done), 32'h0);

    // ROL by WIDTH restores the value; mid-burst inputs are ignored.
    cyc(1, 1, 6, 0, 0, 8'h3C, 0, 0);
    cyc(1, 0, 4, 0, 0, 0, 1, 8);
    for (int i = 0; i < 8; i++)
      cyc(1, bit'(i % 2), int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1,
          int'($urandom_range(0, 15)));
    check("rol8_out",  32'(out),  32'h3C);
    check("rol8_done", 32'(done), 32'h1);

    // SLL burst of 5 abandoned by reset on the 3rd busy cycle.
    cyc(1, 1, 6, 0, 0, 8'h5A, 0, 0);
    cyc(1, 0, 2, 0, 1, 0, 1, 5);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    check("abort_busy_pre", 32'(busy), 32'h1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    check("abort_out",  32'(out),  32'h00);
    check("abort_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      check("abort_no_done", 32'(done), 32'h0);
    end

    // Randomised traffic, including amounts beyond WIDTH and rare resets.
    for (int i = 0; i < 600; i++)
      cyc(bit'($urandom_range(0, 59) != 0), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          bit'($urandom_range(0, 4) == 0), int'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
